// File: rtl/mm2x2_stream_ctrl.sv
// Stream front end for the 2x2 matrix multiplier: loads eight operand words,
// waits a fixed compute latency, captures the four products and drains them.
module mm2x2_stream_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int LATENCY = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic [DATA_W-1:0] mm_a00,
    output logic [DATA_W-1:0] mm_a01,
    output logic [DATA_W-1:0] mm_a10,
    output logic [DATA_W-1:0] mm_a11,
    output logic [DATA_W-1:0] mm_b00,
    output logic [DATA_W-1:0] mm_b01,
    output logic [DATA_W-1:0] mm_b10,
    output logic [DATA_W-1:0] mm_b11,
    input  logic [ACC_W-1:0]  mm_c00,
    input  logic [ACC_W-1:0]  mm_c01,
    input  logic [ACC_W-1:0]  mm_c10,
    input  logic [ACC_W-1:0]  mm_c11
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // The wait counter only ever reaches LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY - 1);

    logic [1:0]       state_reg;
    logic [2:0]       load_idx_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [1:0]       drain_idx_reg;

    logic [DATA_W-1:0] op_word  [8];
    logic [ACC_W-1:0]  res_word [4];
    logic [ACC_W-1:0]  c_word   [4];

    logic s_fire;
    logic m_fire;
    logic capture;

    assign s_ready = (state_reg == ST_LOAD) & ~rst;
    assign m_valid = (state_reg == ST_DRAIN) & ~rst;
    assign busy    = (state_reg == ST_WAIT) | (state_reg == ST_DRAIN);
    assign s_fire  = s_ready & s_valid;
    assign m_fire  = m_valid & m_ready;
    assign capture = (state_reg == ST_WAIT) && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            load_idx_reg  <= 3'd0;
            wait_cnt_reg  <= '0;
            drain_idx_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (s_fire) begin
                        load_idx_reg <= load_idx_reg + 3'd1;
                        if (load_idx_reg == 3'd7) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        state_reg     <= ST_DRAIN;
                        drain_idx_reg <= 2'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_fire) begin
                        drain_idx_reg <= drain_idx_reg + 2'd1;
                        if (drain_idx_reg == 2'd3) begin
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

    // Each operand register loads only on the accept that targets its slot,
    // so a partial reload leaves the later words of the previous job intact.
    for (genvar gi = 0; gi < 8; gi++) begin : g_op
        logic [DATA_W-1:0] word_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg <= '0;
            end else if (s_fire && (load_idx_reg == 3'(gi))) begin
                word_reg <= s_data;
            end
        end
        assign op_word[gi] = word_reg;
    end

    assign c_word[0] = mm_c00;
    assign c_word[1] = mm_c01;
    assign c_word[2] = mm_c10;
    assign c_word[3] = mm_c11;

    for (genvar gi = 0; gi < 4; gi++) begin : g_res
        logic [ACC_W-1:0] word_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg <= '0;
            end else if (capture) begin
                word_reg <= c_word[gi];
            end
        end
        assign res_word[gi] = word_reg;
    end

    assign mm_a00 = op_word[0];
    assign mm_a01 = op_word[1];
    assign mm_a10 = op_word[2];
    assign mm_a11 = op_word[3];
    assign mm_b00 = op_word[4];
    assign mm_b01 = op_word[5];
    assign mm_b10 = op_word[6];
    assign mm_b11 = op_word[7];

    // Result regs and index only move on capture/handshake, so m_data holds under backpressure.
    assign m_data = res_word[drain_idx_reg];
    assign m_last = m_valid & (drain_idx_reg == 2'd3);

endmodule

// File: tb/tb_mm2x2_stream_ctrl.sv
// Bench for mm2x2_stream_ctrl: table jobs, corner sequences and random jobs,
// with a matrix-product scoreboard and a multiplier model valid only at capture time.
module tb_mm2x2_stream_ctrl;

    localparam int LAT = 20;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic [15:0] mm_a00, mm_a01, mm_a10, mm_a11;
    logic [15:0] mm_b00, mm_b01, mm_b10, mm_b11;
    logic [31:0] mm_c00, mm_c01, mm_c10, mm_c11;

    mm2x2_stream_ctrl #(.DATA_W(16), .ACC_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy),
        .mm_a00(mm_a00), .mm_a01(mm_a01), .mm_a10(mm_a10), .mm_a11(mm_a11),
        .mm_b00(mm_b00), .mm_b01(mm_b01), .mm_b10(mm_b10), .mm_b11(mm_b11),
        .mm_c00(mm_c00), .mm_c01(mm_c01), .mm_c10(mm_c10), .mm_c11(mm_c11)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Cycle counter and the edge number of the most recent 8th operand accept.
    int cyc = 0;
    int e8  = -1000;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: correct products only in the cycle before the
    // required capture edge, garbage otherwise, so early/late capture shows up.
    logic [31:0] p00, p01, p10, p11;
    logic        c_ok;
    assign p00 = 32'(mm_a00) * 32'(mm_b00) + 32'(mm_a01) * 32'(mm_b10);
    assign p01 = 32'(mm_a00) * 32'(mm_b01) + 32'(mm_a01) * 32'(mm_b11);
    assign p10 = 32'(mm_a10) * 32'(mm_b00) + 32'(mm_a11) * 32'(mm_b10);
    assign p11 = 32'(mm_a10) * 32'(mm_b01) + 32'(mm_a11) * 32'(mm_b11);
    assign c_ok   = (cyc == e8 + LAT - 1);
    assign mm_c00 = c_ok ? p00 : 32'hDEAD_0000;
    assign mm_c01 = c_ok ? p01 : 32'hDEAD_0001;
    assign mm_c10 = c_ok ? p10 : 32'hDEAD_0002;
    assign mm_c11 = c_ok ? p11 : 32'hDEAD_0003;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic [15:0] acc_q[$];
    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    int          job_no = 0;

    // Reference: C = A x B over 2x2 matrices, row-major, wrapping at 32 bits.
    function automatic void push_expected();
        logic [31:0] a [2][2];
        logic [31:0] b [2][2];
        exp_t        e;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                a[i][j] = 32'(acc_q[2*i+j]);
                b[i][j] = 32'(acc_q[4+2*i+j]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                e.d = 32'd0;
                for (int k = 0; k < 2; k++) e.d = e.d + a[i][k] * b[k][j];
                e.last = (i == 1) && (j == 1);
                exp_q.push_back(e);
            end
    endfunction

    logic        rst_prev     = 1'b0;
    logic        post_last    = 1'b0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    // Monitor: values seen at negedge are what the next posedge samples.
    always @(negedge clk) begin
        if (rst) begin
            chk("s_ready_in_rst", s_ready, 1'b0);
            chk("m_valid_in_rst", m_valid, 1'b0);
            if (rst_prev) begin
                chk("busy_after_rst", busy, 1'b0);
                chk("m_last_after_rst", m_last, 1'b0);
                chk("m_data_after_rst", m_data, 32'd0);
                chk("ops_after_rst", {mm_a00, mm_a01, mm_a10, mm_a11}, 64'd0);
                chk("opb_after_rst", {mm_b00, mm_b01, mm_b10, mm_b11}, 64'd0);
            end
            acc_q.delete();
            exp_q.delete();
            e8           = -1000;
            post_last    = 1'b0;
            hold_pending = 1'b0;
        end else begin
            chk("streams_exclusive", s_ready && (m_valid || busy), 1'b0);
            if (rst_prev) begin
                chk("s_ready_after_rst", s_ready, 1'b1);
                chk("busy_idle_after_rst", busy, 1'b0);
            end
            if (post_last) begin
                chk("s_ready_after_last", s_ready, 1'b1);
                post_last = 1'b0;
            end
            if (cyc == e8 + LAT - 1) begin
                chk("wait_no_valid_early", m_valid, 1'b0);
                chk("wait_busy", busy, 1'b1);
            end
            if (cyc == e8 + LAT) chk("valid_at_latency", m_valid, 1'b1);
            if (hold_pending) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_data);
                chk("hold_last", m_last, hold_last);
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            if (s_valid && s_ready) begin
                acc_q.push_back(s_data);
                if (acc_q.size() == 8) begin
                    push_expected();
                    acc_q.delete();
                    e8 = cyc + 1;
                end
            end
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                $display("job %0d out %0d data=%08h last=%0b", job_no, got_q.size() - 1, m_data, m_last);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    chk("out_data", m_data, exp_q[0].d);
                    chk("out_last", m_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                if (m_last) post_last = 1'b1;
            end
        end
        rst_prev = rst;
    end

    typedef struct {
        logic [7:0][15:0] ops;
        logic [3:0][31:0] res;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input int o0, o1, o2, o3, o4, o5, o6, o7,
                                input int r0, r1, r2, r3);
        vec_t v;
        v.ops[0] = 16'(o0); v.ops[1] = 16'(o1); v.ops[2] = 16'(o2); v.ops[3] = 16'(o3);
        v.ops[4] = 16'(o4); v.ops[5] = 16'(o5); v.ops[6] = 16'(o6); v.ops[7] = 16'(o7);
        v.res[0] = 32'(r0); v.res[1] = 32'(r1); v.res[2] = 32'(r2); v.res[3] = 32'(r3);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("send_timeout", 1'b1, 1'b0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on the second word
    task automatic collect(input int n, input int mode);
        int stall = 0;
        for (int t = 0; t < LAT + 300; t++) begin
            if (got_q.size() >= n) begin
                s_valid = 1'b0;
                m_ready = 1'b0;
                return;
            end
            case (mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (got_q.size() == 1 && m_valid && stall < 3) begin
                        m_ready = 1'b0;
                        stall++;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("collect_timeout", 1'b1, 1'b0);
    endtask

    task automatic run_job(input logic [7:0][15:0] ops, input int gap, input int mode,
                           input bit extras, input bit use_tbl, input logic [3:0][31:0] res);
        job_no++;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            send_word(ops[i]);
            if (gap > 0 && i < 7) repeat (gap) tick();
        end
        if (extras) begin
            s_data  = 16'hEEEE;
            s_valid = 1'b1;
        end
        collect(4, mode);
        if (use_tbl) begin
            for (int k = 0; k < 4; k++)
                chk("table_result", (k < got_q.size()) ? got_q[k] : 32'hXXXX_XXXX, res[k]);
        end
    endtask

    initial begin
        vec_t rv;
        rst     = 1'b1;
        s_data  = 16'd0;
        s_valid = 1'b0;
        m_ready = 1'b0;

        vecs[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
        vecs[1] = mk(1, 0, 0, 1, 5, 6, 7, 8, 5, 6, 7, 8);
        vecs[2] = mk(2, 0, 0, 2, 3, 4, 5, 6, 6, 8, 10, 12);
        vecs[3] = mk(16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0, 32'hFFFE0001, 0, 0, 0);
        vecs[4] = mk(0, 0, 0, 0, 9, 9, 9, 9, 0, 0, 0, 0);

        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_mm_a00", mm_a00, 16'd0);
        rst = 1'b0;
        tick();
        chk("ready_out_of_reset", s_ready, 1'b1);

        // basic job, stalled second word, gapped input with extras during WAIT/DRAIN
        run_job(vecs[0].ops, 0, 0, 1'b0, 1'b1, vecs[0].res);
        run_job(vecs[0].ops, 0, 2, 1'b0, 1'b1, vecs[0].res);
        run_job(vecs[0].ops, 1, 0, 1'b1, 1'b1, vecs[0].res);
        // back-to-back jobs
        run_job(vecs[0].ops, 0, 0, 1'b0, 1'b1, vecs[0].res);
        run_job(vecs[1].ops, 0, 0, 1'b0, 1'b1, vecs[1].res);
        for (int v = 0; v < 5; v++)
            run_job(vecs[v].ops, v % 2, 1, 1'b0, 1'b1, vecs[v].res);
        chk("operands_retained", {mm_a00, mm_b11}, {16'd0, 16'd9});

        // reset after 5 accepted words
        for (int i = 0; i < 5; i++) send_word(vecs[0].ops[i]);
        rst = 1'b1;
        repeat (2) tick();
        chk("partial_load_cleared", {mm_a00, mm_b00}, 32'd0);
        rst = 1'b0;
        tick();
        run_job(vecs[0].ops, 0, 0, 1'b0, 1'b1, vecs[0].res);

        // reset during DRAIN after two words
        job_no++;
        got_q.delete();
        for (int i = 0; i < 8; i++) send_word(vecs[0].ops[i]);
        collect(2, 0);
        chk("drain_partial_count", got_q.size(), 2);
        chk("drain_partial_c01", (got_q.size() > 1) ? got_q[1] : 32'd0, 32'd22);
        rst     = 1'b1;
        m_ready = 1'b1;
        repeat (2) tick();
        rst     = 1'b0;
        tick();
        chk("no_valid_after_drain_rst", m_valid, 1'b0);
        m_ready = 1'b0;

        // random jobs against the scoreboard
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 8; i++) rv.ops[i] = 16'($urandom);
            rv.res = '0;
            run_job(rv.ops, int'($urandom_range(0, 2)), 1, 1'($urandom_range(0, 1)), 1'b0, rv.res);
        end

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
